// File: rtl/fpmul_pkg.sv
// Shared definitions for the floating-point multiplier scheduler.
package fpmul_pkg;

    // Multiplier number-class encoding on num_value.
    localparam logic [2:0] NUM_NORM   = 3'd0;
    localparam logic [2:0] NUM_DENORM = 3'd1;
    localparam logic [2:0] NUM_ZERO   = 3'd2;
    localparam logic [2:0] NUM_INF    = 3'd3;
    localparam logic [2:0] NUM_NAN    = 3'd4;

    localparam int unsigned RSP_FLAGS_W = 5;

    typedef struct packed {
        logic [2:0] num_value;
        logic       over_flow;
        logic       under_flow;
    } fp_flags_t;

endpackage

// File: rtl/fpmul_rsp_fifo.sv
// Synchronous show-ahead FIFO; read data is the head entry whenever non-empty.
module fpmul_rsp_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Status and head-of-queue view; zeros while empty so outputs are clean after reset.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        pop     = rd_en & ~empty;
        push    = wr_en & (~full | pop);
        rd_data = empty ? '0 : mem[rd_ptr];
    end

    // Storage array; not reset, contents are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fpmul_sched.sv
// Round-robin scheduler sharing one pipelined FP multiplier among NREQ requesters.
// In-flight ops are tracked by a tag pipeline; credits reserve FIFO space at issue.
module fpmul_sched
    import fpmul_pkg::*;
#(
    parameter int unsigned DW         = 16,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned PIPE_LAT   = 5,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned IDW        = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic               mul_en,
    output logic [DW-1:0]      mul_a,
    output logic [DW-1:0]      mul_b,
    input  logic [DW-1:0]      mul_result,
    input  logic [2:0]         mul_num_value,
    input  logic               mul_over_flow,
    input  logic               mul_under_flow,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_data,
    output logic [4:0]         rsp_flags
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = IDW + DW + RSP_FLAGS_W;

    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  credit;
    logic           iss_vld;
    logic [IDW-1:0] iss_id;

    logic [PIPE_LAT-1:0] tag_vld;
    logic [IDW-1:0]      tag_id [PIPE_LAT];

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  winner;
    logic            any_valid;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic            accept;
    int unsigned     idx;

    logic            fifo_wr;
    logic [EW-1:0]   fifo_wdata;
    logic [EW-1:0]   fifo_rdata;
    logic            fifo_empty;
    logic            fifo_full;
    logic [CW-1:0]   fifo_count;
    logic            pop;
    fp_flags_t       in_flags;

    // Round-robin search from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!any_valid && req_valid[IDW'(idx)]) begin
                any_valid  = 1'b1;
                winner     = IDW'(idx);
                grant[idx] = 1'b1;
                sel_a      = req_a[idx*DW +: DW];
                sel_b      = req_b[idx*DW +: DW];
            end
        end
        req_ready = grant & {NREQ{credit != '0}};
        accept    = any_valid & (credit != '0);
    end

    // Enable runs the multiplier while anything is issued or in flight; FIFO write at tag exit.
    always_comb begin
        mul_en              = iss_vld | (|tag_vld);
        in_flags.num_value  = mul_num_value;
        in_flags.over_flow  = mul_over_flow;
        in_flags.under_flow = mul_under_flow;
        fifo_wr             = mul_en & tag_vld[PIPE_LAT-1];
        fifo_wdata          = {tag_id[PIPE_LAT-1], mul_result, in_flags};
        rsp_valid           = ~fifo_empty;
        pop                 = rsp_valid & rsp_ready;
        rsp_id              = fifo_rdata[EW-1 -: IDW];
        rsp_data            = fifo_rdata[RSP_FLAGS_W +: DW];
        rsp_flags           = fifo_rdata[RSP_FLAGS_W-1:0];
    end

    // Pointer advance and issue register capture on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            iss_vld <= 1'b0;
            iss_id  <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else begin
            iss_vld <= accept;
            if (accept) begin
                rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
                iss_id <= winner;
                mul_a  <= sel_a;
                mul_b  <= sel_b;
            end
        end
    end

    // Tag pipeline advances in lockstep with the enable-gated multiplier stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else if (mul_en) begin
            tag_vld[0] <= iss_vld;
            tag_id[0]  <= iss_id;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    // Credits reserve a FIFO slot at accept and return it on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= CW'(FIFO_DEPTH);
        end else if (accept && !pop) begin
            credit <= credit - CW'(1);
        end else if (pop && !accept) begin
            credit <= credit + CW'(1);
        end
    end

    fpmul_rsp_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (rsp_ready),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Every slot is exactly one of: free credit, in flight, or queued.
    a_credit_balance : assert property (@(posedge clk) disable iff (rst)
        (32'(credit) + 32'(iss_vld) + 32'($countones(tag_vld)) + 32'(fifo_count))
            == FIFO_DEPTH);

    a_no_fifo_overrun : assert property (@(posedge clk) disable iff (rst)
        fifo_wr |-> (!fifo_full || pop));

endmodule

// File: tb/tb_fpmul_sched.sv
// Randomised scoreboard bench for fpmul_sched with a behavioural multiplier stand-in.
module tb_fpmul_sched;

    localparam int DW         = 16;
    localparam int NREQ       = 4;
    localparam int PIPE_LAT   = 5;
    localparam int FIFO_DEPTH = 8;
    localparam int IDW        = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    data;
        logic [4:0]     flags;
        int             due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic               mul_en;
    logic [DW-1:0]      mul_a;
    logic [DW-1:0]      mul_b;
    logic [DW-1:0]      mul_result;
    logic [2:0]         mul_num_value;
    logic               mul_over_flow;
    logic               mul_under_flow;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;
    logic [4:0]         rsp_flags;

    logic [DW-1:0] op_a [NREQ];
    logic [DW-1:0] op_b [NREQ];
    logic [20:0]   pipe [PIPE_LAT];

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_credit = FIFO_DEPTH;
    int   m_rr = 0;
    bit   started = 0;
    bit   rst_done = 0;
    bit   acc_now = 0;
    int   acc_w = 0;
    bit   pop_now = 0;
    int   hs_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = op_a[i];
            req_b[i*DW +: DW] = op_b[i];
        end
    end

    fpmul_sched dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .mul_en         (mul_en),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_result     (mul_result),
        .mul_num_value  (mul_num_value),
        .mul_over_flow  (mul_over_flow),
        .mul_under_flow (mul_under_flow),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_flags      (rsp_flags)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Simplified binary16 multiply: {result[15:0], num_value[2:0], over_flow, under_flow}.
    function automatic logic [20:0] mul_model(input logic [15:0] a, input logic [15:0] b);
        logic       s;
        logic [4:0] ea, eb;
        logic [9:0] ma, mb, m;
        logic [21:0] p;
        int         e;
        bit         nan_a, nan_b, inf_a, inf_b, zer_a, zer_b, den_a, den_b;
        s  = a[15] ^ b[15];
        ea = a[14:10]; eb = b[14:10];
        ma = a[9:0];   mb = b[9:0];
        nan_a = (ea == 5'h1f) && (ma != 0); nan_b = (eb == 5'h1f) && (mb != 0);
        inf_a = (ea == 5'h1f) && (ma == 0); inf_b = (eb == 5'h1f) && (mb == 0);
        zer_a = (ea == 0) && (ma == 0);     zer_b = (eb == 0) && (mb == 0);
        den_a = (ea == 0) && (ma != 0);     den_b = (eb == 0) && (mb != 0);
        if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a))
            return {16'h7E00, 3'd4, 2'b00};
        if (inf_a || inf_b) return {s, 5'h1f, 10'd0, 3'd3, 2'b00};
        if (zer_a || zer_b) return {s, 15'd0, 3'd2, 2'b00};
        if (den_a || den_b) return {s, 15'd0, 3'd1, 2'b01};
        p = {1'b1, ma} * {1'b1, mb};
        e = int'(ea) + int'(eb) - 15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 1;
        end else begin
            m = p[19:10];
        end
        if (e >= 31) return {s, 5'h1f, 10'd0, 3'd3, 2'b10};
        if (e <= 0)  return {s, 15'd0, 3'd2, 2'b01};
        return {s, e[4:0], m, 3'd0, 2'b00};
    endfunction

    function automatic logic [15:0] pick_op();
        case ($urandom_range(0, 7))
            0:       return 16'h7E00;
            1:       return 16'h7C00;
            2:       return 16'h0000;
            3:       return 16'h0200;
            4:       return 16'h7BFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Enable-gated multiplier stand-in with PIPE_LAT stages and no reset.
    always @(posedge clk) begin
        if (mul_en) begin
            pipe[0] <= mul_model(mul_a, mul_b);
            for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_result     = pipe[PIPE_LAT-1][20:5];
    assign mul_num_value  = pipe[PIPE_LAT-1][4:2];
    assign mul_over_flow  = pipe[PIPE_LAT-1][1];
    assign mul_under_flow = pipe[PIPE_LAT-1][0];

    // Model bookkeeping committed on the clock edge the DUT also uses.
    always @(posedge clk) begin
        started  <= 1'b1;
        rst_done <= rst;
        cyc      <= cyc + 1;
        if (rst) begin
            exp_q.delete();
            m_credit <= FIFO_DEPTH;
            m_rr     <= 0;
        end else begin
            m_credit <= m_credit - int'(acc_now) + int'(pop_now);
            if (acc_now) m_rr <= (acc_w + 1) % NREQ;
        end
    end

    // Arbitration/credit model: predicts req_ready and queues the expected response.
    int   w_m;
    exp_t e_new;
    always @(negedge clk) begin
        acc_now = 0;
        if (started) begin
            if (rst_done && rst) begin
                chk("rst_mul_en", mul_en, 0);
                chk("rst_mul_a", mul_a, 0);
                chk("rst_mul_b", mul_b, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_fields", {rsp_id, rsp_data, rsp_flags}, 0);
            end
            w_m = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w_m < 0 && req_valid[(m_rr + k) % NREQ]) w_m = (m_rr + k) % NREQ;
            end
            chk("req_ready", req_ready,
                (w_m >= 0 && m_credit != 0) ? (32'd1 << w_m) : 32'd0);
            chk("credit", dut.credit, m_credit);
            if (|(req_valid & req_ready)) hs_cnt++;
            if (w_m >= 0 && m_credit != 0) begin
                acc_now = 1;
                acc_w   = w_m;
                e_new.id = IDW'(w_m);
                {e_new.data, e_new.flags} = mul_model(op_a[w_m], op_b[w_m]);
                e_new.due = cyc + PIPE_LAT + 2;
                exp_q.push_back(e_new);
            end
        end
    end

    // Response monitor: compares whatever the DUT presents against the queue head.
    bit exp_v;
    always @(negedge clk) begin
        pop_now = 0;
        if (started) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            chk("rsp_valid", rsp_valid, exp_v);
            if (rsp_valid && exp_q.size() > 0) begin
                chk("rsp_id", rsp_id, exp_q[0].id);
                chk("rsp_data", rsp_data, exp_q[0].data);
                chk("rsp_flags", rsp_flags, exp_q[0].flags);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    pop_now = 1;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int lat;
    int base;
    int wi;

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        tick(3);
        rst = 0;
        tick(1);

        // Single request from requester 2: 1.0 * 2.0.
        rsp_ready = 1;
        op_a[2] = 16'h3C00; op_b[2] = 16'h4000;
        req_valid = 4'b0100;
        tick(1);
        req_valid = 0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        chk("single_latency", lat, 7);
        chk("single_id", rsp_id, 2);
        chk("single_data", rsp_data, 16'h4000);
        chk("single_flags", rsp_flags, 0);
        tick(10);

        // All requesters valid from reset: strict rotation 0,1,2,3,...
        rst = 1;
        tick(2);
        rst = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = pick_op(); op_b[i] = pick_op();
        end
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wi = -1;
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) wi = k;
            chk("rr_order", wi, i % NREQ);
            tick(1);
        end
        req_valid = 0;
        tick(15);

        // Back-pressure: credits cap outstanding work at FIFO_DEPTH.
        rsp_ready = 0;
        base = hs_cnt;
        req_valid = 4'hF;
        tick(20);
        chk("bp_accepts", hs_cnt - base, 8);
        @(negedge clk);
        chk("bp_ready_zero", req_ready, 0);
        tick(1);
        rsp_ready = 1;
        tick(1);
        rsp_ready = 0;
        tick(5);
        chk("one_pop_one_accept", hs_cnt - base, 9);
        tick(10);
        // Pops overlapping accepts while the FIFO is full.
        rsp_ready = 1;
        tick(3);
        rsp_ready = 0;
        tick(10);
        chk("overlap_accepts", hs_cnt - base, 12);
        req_valid = 0;
        rsp_ready = 1;
        tick(20);
        @(negedge clk);
        chk("drain_credit", dut.credit, FIFO_DEPTH);
        tick(1);

        // NaN and infinity operands are ordinary responses.
        op_a[1] = 16'h7E00; op_b[1] = 16'h0000;
        req_valid = 4'b0010;
        tick(1);
        op_a[1] = 16'h7C00;
        tick(1);
        req_valid = 0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        chk("nan_num_value", rsp_flags[4:2], 4);
        @(negedge clk);
        chk("inf_x_zero_valid", rsp_valid, 1);
        chk("inf_x_zero_num_value", rsp_flags[4:2], 4);
        tick(10);

        // Reset with 2 queued and 3 in flight discards everything.
        rsp_ready = 0;
        op_a[3] = pick_op(); op_b[3] = pick_op();
        req_valid = 4'b1000;
        tick(2);
        req_valid = 0;
        tick(10);
        req_valid = 4'b1000;
        tick(3);
        req_valid = 0;
        rst = 1;
        tick(2);
        rst = 0;
        rsp_ready = 1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 4'b0001);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_credit", dut.credit, FIFO_DEPTH);
        tick(1);
        req_valid = 0;
        tick(20);

        // Randomised traffic with back-pressure bursts.
        for (int n = 0; n < 3000; n++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = pick_op(); op_b[i] = pick_op();
            end
            rsp_ready = ((n % 200) < 50) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick(1);
        end
        req_valid = 0;
        rsp_ready = 1;
        tick(30);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpmul_sched.md
# fpmul_sched

Shares one pipelined floating-point multiplier among `NREQ` requesters. Each request is an operand pair with a valid/ready handshake. The block arbitrates round-robin, issues one multiply per cycle at most, and tracks in-flight operations with a tag shift register matched to the multiplier latency. Results are returned, with the requester ID, through a credit-protected response FIFO, so no result is ever dropped under back-pressure. It sits between the request ports and the multiplier's stage-1 inputs and stage-5 outputs. The multiplier runs in enable-gated mode (`CG_EN=0`).

## Interface
- `DW`, 16: floating-point word width.
- `NREQ`, 4: number of requesters, 2..8.
- `PIPE_LAT`, 5: multiplier latency, in enabled clock edges from `mul_a`/`mul_b` to `mul_result`.
- `FIFO_DEPTH`, 8: response FIFO entries, a power of two, at least 2.
- `IDW`, `$clog2(NREQ)`: requester ID width (derived).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: request valid, one bit per requester.
- `req_ready` out NREQ: request accepted this cycle (per requester).
- `req_a` in NREQ*DW: operand A; requester i owns bits `[i*DW +: DW]`.
- `req_b` in NREQ*DW: operand B; same packing as `req_a`.
- `mul_en` out 1: multiplier pipeline enable.
- `mul_a` out DW: registered operand A to the multiplier.
- `mul_b` out DW: registered operand B to the multiplier.
- `mul_result` in DW: multiplier `out_result`.
- `mul_num_value` in 3: multiplier class (0 norm, 1 denorm, 2 zero, 3 inf, 4 NaN).
- `mul_over_flow` in 1: multiplier overflow flag.
- `mul_under_flow` in 1: multiplier underflow flag.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer pops the response.
- `rsp_id` out IDW: requester that owns the response.
- `rsp_data` out DW: product.
- `rsp_flags` out 5: `{num_value, over_flow, under_flow}`.

## Operation
- **Arbiter**
  - Round-robin pointer `rr_ptr`, IDW bits.
  - Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping.
  - `req_ready[i] = grant[i] & (credit != 0)`. At most one `req_ready` bit is high per cycle. `req_ready` may depend on `req_valid`; `req_valid` must not depend on `req_ready`.
  - On accept (valid & ready), `rr_ptr` becomes winner+1 modulo NREQ. It is unchanged otherwise.
- **Issue register**
  - On accept, capture the operands into `mul_a`/`mul_b` and set `iss_vld` with `iss_id`.
  - With no accept, `iss_vld` clears and `mul_a`/`mul_b` hold their values.
- **Enable and tag pipeline**
  - `mul_en = iss_vld | (|tag_vld)`.
  - Tag shift register: PIPE_LAT entries of `{vld, id}`. It shifts only when `mul_en` is high. Entry 0 loads `{iss_vld, iss_id}`.
  - When the last entry is valid and `mul_en` is high, the multiplier output is written into the FIFO on that edge.
- **Credits**
  - `credit` is `$clog2(FIFO_DEPTH+1)` bits wide and resets to FIFO_DEPTH.
  - Decrement on accept, increment on a pop (`rsp_valid & rsp_ready`). Both in the same cycle leave it unchanged.
  - Invariant: `credit + inflight + fifo_count == FIFO_DEPTH`. Overflow and underflow are impossible by construction; assert this in simulation.
- **Response FIFO**
  - Entries hold `{id, data, flags}`, show-ahead.
  - `rsp_valid` is high whenever the FIFO is non-empty.
  - Write and pop in the same cycle are allowed, including when the FIFO is full (credit guarantees space) and when it is empty (pop is not possible because `rsp_valid` is 0).
- **Flags** pass through unmodified. NaN, infinity and overflow results are ordinary responses.
- **Ordering**: responses come out in issue order globally, and therefore in order per requester.

## Timing
- Reset values:
  - `req_ready` 0, `mul_en` 0, `mul_a`/`mul_b` 0, `rsp_valid` 0, `rsp_id`/`rsp_data`/`rsp_flags` 0.
  - `rr_ptr` 0, `iss_vld` 0, all tag `vld` bits 0, `credit` FIFO_DEPTH, FIFO empty.
- Accept at edge T: `mul_en`/`mul_a`/`mul_b` are valid in cycle T+1, the FIFO is written at edge T+1+PIPE_LAT, and `rsp_valid` rises in cycle T+2+PIPE_LAT. With the defaults, accept to `rsp_valid` is 7 cycles.
- Throughput is 1 accept per cycle while `credit > 0`.
- `rsp_ready` held 0: accepts stop after FIFO_DEPTH outstanding operations, and `req_ready` is all-zero from then on.
- Reset mid-operation: all in-flight and queued results are discarded. Stale multiplier pipeline data is ignored because the tag `vld` bits are cleared. The first post-reset accept is possible in the cycle after `rst` deasserts.

## Structure
- Package `fpmul_pkg`:
  - `NUM_NORM`..`NUM_NAN` constants (0..4).
  - `fp_flags_t` struct `{num_value[2:0], over_flow, under_flow}`.
  - `RSP_FLAGS_W = 5`.
- Sub-module `fpmul_rsp_fifo`: synchronous show-ahead FIFO with parameters `W` and `DEPTH`. It is reusable elsewhere in the core.
- The arbiter, issue register, tag pipeline and credit counter are inline in `fpmul_sched`.

## Test plan
- Single request, requester 2, A=0x3C00 (1.0), B=0x4000 (2.0), `rsp_ready`=1 -> `rsp_valid` 7 cycles after accept, `rsp_id`=2, `rsp_data`=0x4000, `rsp_flags`=0.
- All 4 requesters hold `req_valid` for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; responses in the same order with matching IDs.
- `rsp_ready`=0 with continuous requests -> exactly 8 accepts, then `req_ready` is all-zero; one pop -> exactly one further accept.
- FIFO full with a pop and a new accept in the same cycle -> `credit` stays 0, no lost or duplicated response; the scoreboard matches every response.
- Requests A=0x7E00 (NaN) and A=0x7C00 (inf) × B=0x0000 -> both responses carry `num_value`=4 and are delivered normally.
- `rst` pulsed with 3 operations in flight and 2 queued -> `rsp_valid`=0 and `credit`=8 after reset; no stale response ever appears.
